// File: rtl/xor_csum_pkg.sv
// Shared defaults and state encoding for the XOR checksum arbiter.
// Imported by the round-robin arbiter and the top level.
package xor_csum_pkg;

    localparam int NREQ_DEF = 4;
    localparam int W_DEF    = 8;
    localparam int ID_W_DEF = $clog2(NREQ_DEF);

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t BUSY = 2'd1;
    localparam state_t DONE = 2'd2;

endpackage

// File: rtl/xor_csum_arb_rr_arb.sv
// Combinational round-robin picker: the first requester after ptr wins,
// so the requester at ptr itself is considered last.
module rr_arb
    import xor_csum_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [IDW-1:0]  grant,
    output logic            any_req
);

    logic [IDW-1:0] idx;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        grant   = '0;
        any_req = 1'b0;
        idx     = '0;
        // Walk from the farthest offset to the nearest so the nearest hit overwrites the rest.
        for (int k = NREQ; k >= 1; k--) begin
            idx = IDW'((int'(ptr) + k) % NREQ);
            if (req[idx]) begin
                grant   = idx;
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/xor_csum_arb.sv
// Shared XOR checksum engine: round-robin grants one requester a whole packet,
// folds its words into an accumulator and holds the result until accepted.
module xor_csum_arb
    import xor_csum_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int W    = W_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*W-1:0]        req_data,
    input  logic [NREQ-1:0]          req_last,
    output logic [NREQ-1:0]          req_ready,
    output logic                     csum_valid,
    output logic [W-1:0]             csum_data,
    output logic [$clog2(NREQ)-1:0]  csum_id,
    input  logic                     csum_ready
);

    localparam int IDW = $clog2(NREQ);

    state_t         state;
    logic [IDW-1:0] grant;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] arb_grant;
    logic           arb_any;
    logic [W-1:0]   acc;
    logic [W-1:0]   word;
    logic [W-1:0]   acc_next;
    logic           xfer;

    rr_arb #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_arb (
        .req     (req_valid),
        .ptr     (ptr),
        .grant   (arb_grant),
        .any_req (arb_any)
    );

    assign word       = req_data[int'(grant)*W +: W];
    assign xfer       = (state == BUSY) && req_valid[grant];
    assign acc_next   = acc ^ word;
    assign csum_valid = (state == DONE);

    // Only the owner of the current packet ever sees ready.
    always_comb begin
        req_ready = '0;
        if (state == BUSY) begin
            req_ready[grant] = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            grant     <= '0;
            ptr       <= IDW'(NREQ - 1);
            acc       <= '0;
            csum_data <= '0;
            csum_id   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (arb_any) begin
                        grant <= arb_grant;
                        acc   <= '0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (xfer) begin
                        acc <= acc_next;
                        if (req_last[grant]) begin
                            csum_data <= acc_next;
                            csum_id   <= grant;
                            state     <= DONE;
                        end
                    end
                end
                DONE: begin
                    // The finishing requester becomes lowest priority for the next search.
                    if (csum_ready) begin
                        ptr   <= grant;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xor_csum_arb.sv
// Self-checking bench for xor_csum_arb: table of single-packet vectors, directed
// multi-cycle sequences and randomized traffic against a packet-level model.
module tb_xor_csum_arb;
    import xor_csum_pkg::*;

    localparam int NREQ = NREQ_DEF;
    localparam int W    = W_DEF;
    localparam int IDW  = $clog2(NREQ);

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ*W-1:0] req_data = '0;
    logic [NREQ-1:0]   req_last = '0;
    logic [NREQ-1:0]   req_ready;
    logic              csum_valid;
    logic [W-1:0]      csum_data;
    logic [IDW-1:0]    csum_id;
    logic              csum_ready = 1'b0;

    xor_csum_arb #(.NREQ(NREQ), .W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .csum_valid (csum_valid),
        .csum_data  (csum_data),
        .csum_id    (csum_id),
        .csum_ready (csum_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           id;
        int           n;
        logic [W-1:0] w [4];
        logic [W-1:0] exp;
    } vec_t;

    int           vectors = 0;
    int           miscompares = 0;
    logic [W-1:0] wq [NREQ][$];
    bit           lq [NREQ][$];
    logic [W-1:0] eq [NREQ][$];
    int           got_ids [$];
    int           last_served = NREQ - 1;
    vec_t         vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_word(input int i, input logic [W-1:0] d, input logic l);
        req_data[i*W +: W] = d;
        req_last[i]        = l;
    endtask

    task automatic clear_model();
        for (int i = 0; i < NREQ; i++) begin
            wq[i].delete();
            lq[i].delete();
            eq[i].delete();
        end
        got_ids.delete();
        last_served = NREQ - 1;
    endtask

    task automatic apply_reset(input string tag);
        req_valid  = '0;
        req_data   = '0;
        req_last   = '0;
        csum_ready = 1'b0;
        clear_model();
        rst_n = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        check({tag, "_rst_valid"}, csum_valid, 0);
        check({tag, "_rst_ready"}, req_ready, 0);
        check({tag, "_rst_data"}, csum_data, 0);
        check({tag, "_rst_id"}, csum_id, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic load_vec(input vec_t v);
        for (int j = 0; j < v.n; j++) begin
            wq[v.id].push_back(v.w[j]);
            lq[v.id].push_back(j == v.n - 1);
        end
        eq[v.id].push_back(v.exp);
    endtask

    function automatic bit queues_empty();
        for (int i = 0; i < NREQ; i++) begin
            if (wq[i].size() != 0 || eq[i].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Round-robin rule: first valid requester after the one that last completed.
    function automatic int next_grant(input logic [NREQ-1:0] v);
        for (int k = 1; k <= NREQ; k++) begin
            if (v[(last_served + k) % NREQ]) return (last_served + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic drive_engine(input int vpct, input int rpct);
        for (int i = 0; i < NREQ; i++) begin
            if (wq[i].size() > 0 && int'($urandom_range(99)) < vpct) begin
                req_valid[i] = 1'b1;
                set_word(i, wq[i][0], lq[i][0]);
            end else begin
                req_valid[i] = 1'b0;
                set_word(i, W'($urandom), 1'($urandom_range(1)));
            end
        end
        csum_ready = (int'($urandom_range(99)) < rpct);
    endtask

    // Plays the queued packets through the DUT and checks every result, grant and latency.
    task automatic run_engine(input int vpct, input int rpct, input int max_cycles, input string tag);
        int              cyc = 0;
        int              owner = -1;
        int              g;
        bit              want_done = 1'b0;
        int              want_id = 0;
        bit              res;
        int              res_id;
        logic [W-1:0]    res_data;
        logic [NREQ-1:0] hs, lasts;
        logic [NREQ-1:0] prev_v = '0;
        logic [NREQ-1:0] prev_r = '0;
        drive_engine(vpct, rpct);
        while (!queues_empty() && cyc < max_cycles) begin
            if (want_done) begin
                check({tag, "_lat_valid"}, csum_valid, 1);
                check({tag, "_lat_id"}, csum_id, want_id);
                want_done = 1'b0;
            end
            check({tag, "_ready_onehot0"}, $onehot0(req_ready), 1);
            if (req_ready != '0 && prev_r == '0) begin
                g = next_grant(prev_v);
                check({tag, "_rr_grant"}, req_ready, (g < 0) ? 0 : (1 << g));
                owner = g;
            end
            hs       = req_valid & req_ready;
            lasts    = hs & req_last;
            res      = csum_valid && csum_ready;
            res_id   = int'(csum_id);
            res_data = csum_data;
            prev_v   = req_valid;
            prev_r   = req_ready;
            tick();
            cyc++;
            for (int i = 0; i < NREQ; i++) begin
                if (hs[i] && wq[i].size() > 0) begin
                    void'(wq[i].pop_front());
                    void'(lq[i].pop_front());
                end
                if (lasts[i]) begin
                    want_done = 1'b1;
                    want_id   = i;
                end
            end
            if (res) begin
                got_ids.push_back(res_id);
                check({tag, "_id_owner"}, res_id, owner);
                check({tag, "_result_pending"}, eq[res_id].size() > 0, 1);
                if (eq[res_id].size() > 0) begin
                    check({tag, "_csum"}, res_data, eq[res_id].pop_front());
                end
                last_served = res_id;
            end
            drive_engine(vpct, rpct);
        end
        check({tag, "_drained"}, queues_empty(), 1);
        req_valid  = '0;
        csum_ready = 1'b0;
    endtask

    task automatic check_ids(input string tag, input int e0, input int e1, input int e2, input int e3);
        int exp_ids [4];
        exp_ids = '{e0, e1, e2, e3};
        check({tag, "_count"}, got_ids.size(), 4);
        for (int k = 0; k < 4 && k < got_ids.size(); k++) begin
            check({tag, "_order"}, got_ids[k], exp_ids[k]);
        end
    endtask

    task automatic gen_random(input int max_pk);
        int           npk, n;
        logic [W-1:0] w, x;
        for (int i = 0; i < NREQ; i++) begin
            npk = int'($urandom_range(max_pk, 1));
            for (int p = 0; p < npk; p++) begin
                n = int'($urandom_range(5, 1));
                x = '0;
                for (int j = 0; j < n; j++) begin
                    w = W'($urandom);
                    x = x ^ w;
                    wq[i].push_back(w);
                    lq[i].push_back(j == n - 1);
                end
                eq[i].push_back(x);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{0, 3, '{8'h3C, 8'hA5, 8'h0F, 8'h00}, 8'h96};
        vecs[1] = '{1, 1, '{8'hFF, 8'h00, 8'h00, 8'h00}, 8'hFF};
        vecs[2] = '{3, 2, '{8'h12, 8'h34, 8'h00, 8'h00}, 8'h26};
        vecs[3] = '{2, 4, '{8'hAA, 8'h55, 8'hF0, 8'h0F}, 8'h00};
        vecs[4] = '{0, 3, '{8'h80, 8'h01, 8'h80, 8'h00}, 8'h01};
        vecs[5] = '{2, 1, '{8'h7E, 8'h00, 8'h00, 8'h00}, 8'h7E};

        apply_reset("init");
        for (int v = 0; v < 6; v++) begin
            load_vec(vecs[v]);
            run_engine(100, 100, 100, $sformatf("vec%0d", v));
        end

        // All four requesters with one-word packets: served 0,1,2,3 from reset.
        apply_reset("all4");
        load_vec('{0, 1, '{8'h01, 8'h00, 8'h00, 8'h00}, 8'h01});
        load_vec('{1, 1, '{8'h02, 8'h00, 8'h00, 8'h00}, 8'h02});
        load_vec('{2, 1, '{8'h04, 8'h00, 8'h00, 8'h00}, 8'h04});
        load_vec('{3, 1, '{8'h08, 8'h00, 8'h00, 8'h00}, 8'h08});
        run_engine(100, 100, 100, "all4");
        check_ids("all4_ids", 0, 1, 2, 3);

        // Granted requester stalls three cycles while others wait.
        apply_reset("stall");
        req_valid = 4'b0111;
        set_word(0, 8'h11, 1'b0);
        set_word(1, 8'h5A, 1'b1);
        set_word(2, 8'hC3, 1'b1);
        tick();
        check("stall_grant", req_ready, 4'b0001);
        tick();
        req_valid[0] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("stall_hold_ready", req_ready, 4'b0001);
            tick();
        end
        req_valid[0] = 1'b1;
        set_word(0, 8'h22, 1'b0);
        tick();
        set_word(0, 8'h44, 1'b1);
        tick();
        req_valid = '0;
        check("stall_valid", csum_valid, 1);
        check("stall_data", csum_data, 8'h77);
        check("stall_id", csum_id, 0);
        check("stall_ready_done", req_ready, 0);
        csum_ready = 1'b1;
        tick();
        csum_ready = 1'b0;
        check("stall_accepted", csum_valid, 0);

        // Result held five cycles with csum_ready low, accepted on the sixth.
        apply_reset("hold");
        req_valid = 4'b1010;
        set_word(1, 8'h5A, 1'b1);
        set_word(3, 8'h3C, 1'b1);
        tick();
        check("hold_grant1", req_ready, 4'b0010);
        tick();
        req_valid[1] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check("hold_valid", csum_valid, 1);
            check("hold_data", csum_data, 8'h5A);
            check("hold_id", csum_id, 1);
            check("hold_no_grant", req_ready, 0);
            tick();
        end
        csum_ready = 1'b1;
        check("hold_valid6", csum_valid, 1);
        tick();
        csum_ready = 1'b0;
        check("hold_idle", csum_valid, 0);
        check("hold_idle_ready", req_ready, 0);
        tick();
        check("hold_grant3", req_ready, 4'b1000);
        tick();
        req_valid = '0;
        check("hold_data3", csum_data, 8'h3C);
        check("hold_id3", csum_id, 3);
        csum_ready = 1'b1;
        tick();
        csum_ready = 1'b0;

        // Reset in the middle of a four-word packet, then a fresh packet.
        req_valid = 4'b0001;
        set_word(0, 8'h01, 1'b0);
        tick();
        tick();
        set_word(0, 8'h02, 1'b0);
        tick();
        set_word(0, 8'h04, 1'b0);
        rst_n     = 1'b0;
        req_valid = '0;
        #1;
        check("midrst_valid", csum_valid, 0);
        check("midrst_ready", req_ready, 0);
        check("midrst_data", csum_data, 0);
        check("midrst_id", csum_id, 0);
        @(posedge clk);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check("midrst_quiet", csum_valid, 0);
            tick();
        end
        clear_model();
        load_vec('{0, 2, '{8'hFF, 8'h0F, 8'h00, 8'h00}, 8'hF0});
        run_engine(100, 100, 100, "midrst_resend");

        // Requesters 2 and 3 both busy: grants must alternate.
        apply_reset("alt");
        load_vec('{2, 1, '{8'h21, 8'h00, 8'h00, 8'h00}, 8'h21});
        load_vec('{2, 2, '{8'h22, 8'h23, 8'h00, 8'h00}, 8'h01});
        load_vec('{3, 1, '{8'h31, 8'h00, 8'h00, 8'h00}, 8'h31});
        load_vec('{3, 2, '{8'h32, 8'h30, 8'h00, 8'h00}, 8'h02});
        run_engine(100, 100, 100, "alt");
        check_ids("alt_ids", 2, 3, 2, 3);

        // Randomized traffic with valid gaps and downstream backpressure.
        apply_reset("rand");
        gen_random(4);
        run_engine(70, 60, 5000, "rand_a");
        gen_random(3);
        run_engine(100, 100, 5000, "rand_b");
        gen_random(4);
        run_engine(40, 30, 8000, "rand_c");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/xor_csum_arb.md
XOR_CSUM_ARB -- requirements
Module: xor_csum_arb

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing the XOR checksum engine.
REQ-002 Parameter W, default 8, data word width.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 req_valid  input  NREQ  per-requester word valid.
REQ-007 req_data  input  NREQ*W  per-requester word; requester i at bits [i*W +: W].
REQ-008 req_last  input  NREQ  per-requester last-word-of-packet flag.
REQ-009 req_ready  output  NREQ  one-hot accept to the granted requester, else all zero.
REQ-010 csum_valid  output  1  checksum result valid.
REQ-011 csum_data  output  W  XOR of all words of the completed packet.
REQ-012 csum_id  output  clog2(NREQ)  index of the requester that owned the packet.
REQ-013 csum_ready  input  1  downstream accepts the result.

Function
REQ-014 The block SHALL implement FSM states IDLE, BUSY, DONE.
REQ-015 IDLE: if any req_valid bit is set, the block SHALL latch a grant by round-robin search starting at ptr+1 (mod NREQ) and go to BUSY next cycle; acc cleared to 0.
REQ-016 IDLE with no req_valid: stay in IDLE, all outputs inactive.
REQ-017 BUSY: req_ready[grant] SHALL be 1, all other bits 0; a word transfers when req_valid[grant] & req_ready[grant].
REQ-018 Each transferred word SHALL update acc <= acc ^ word.
REQ-019 Transfer with req_last[grant]=1: csum_data <= acc ^ word, csum_id <= grant, go to DONE next cycle.
REQ-020 req_valid[grant] low in BUSY: the block SHALL hold grant and acc (stall), no timeout.
REQ-021 Requests from non-granted requesters during BUSY/DONE SHALL be ignored (ready 0) until the packet completes.
REQ-022 DONE: csum_valid=1, csum_data/csum_id stable; req_ready all 0.
REQ-023 DONE with csum_ready=1: ptr <= grant, go to IDLE next cycle; csum_ready low holds DONE indefinitely.
REQ-024 Latency: grant decided in IDLE cycle; first word accepted earliest one cycle later; csum_valid asserted the cycle after the last-word transfer.
REQ-025 Single-word packet (valid and last together) SHALL give csum_data = that word.
REQ-026 Arbitration fairness: after requester k completes, requester k SHALL have lowest priority in the next search.
REQ-027 All XOR arithmetic SHALL be bitwise, width W, no carry.

Reset
REQ-028 On rst_n low: state IDLE, acc 0, csum_data 0, csum_id 0, csum_valid 0, req_ready 0, grant 0, ptr NREQ-1 (requester 0 highest priority first).
REQ-029 Reset mid-packet or in DONE SHALL discard the partial checksum/result; no output after release until a new packet completes.

Structure
REQ-030 A shared package xor_csum_pkg SHALL hold NREQ/W defaults, the state typedef (IDLE, BUSY, DONE) and the id width constant.
REQ-031 Round-robin selection SHALL be a separate sub-module rr_arb (inputs req vector, ptr; outputs grant index, any_req), purely combinational.

Verification
REQ-032 Req 0 only, words 0x3C,0xA5,0x0F (last) -> csum_data 0x96, csum_id 0, csum_valid one cycle after last transfer.
REQ-033 All four valid after reset, each sending one word (0x01,0x02,0x04,0x08, last) -> results in order id 0,1,2,3 with data 0x01,0x02,0x04,0x08.
REQ-034 Granted requester drops valid 3 cycles mid-packet, other requesters valid -> grant held, req_ready of others stays 0, checksum correct.
REQ-035 csum_ready held low 5 cycles in DONE -> csum_valid/data/id stable, no new grant; accepted on sixth cycle, IDLE next.
REQ-036 rst_n asserted after second word of a 4-word packet -> outputs at reset values; re-sent packet 0xFF,0x0F (last) gives 0xF0.
REQ-037 Requester 2 repeatedly valid with requester 3 valid -> alternating grants 2,3,2,3.
